iterative_mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO result registers of the integer pipeline. It computes signed and unsigned WIDTH x WIDTH products with a shift-add datapath and quotient/remainder pairs with a restoring divider, instead of single-cycle operators. It adds a configurable multiply throughput, a flush (cancel) input, a completion pulse and selectable divide-by-zero semantics. It sits beside the execute stage; the pipeline stalls on busy.

---
 rtl/iterative_mul_div_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_iterative_mul_div_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers: shift-add multiplier
// retiring MUL_STEP multiplier bits per cycle, restoring divider, sign fixup cycle.
module iterative_mul_div_unit #(
   parameter int WIDTH         = 32,
   parameter int MUL_STEP      = 1,
   parameter bit DIV_ZERO_KEEP = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [2:0]       operation,
   input  logic             start,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dataRead
);

   localparam logic [2:0] OP_READ_HI  = 3'd0;
   localparam logic [2:0] OP_READ_LO  = 3'd1;
   localparam logic [2:0] OP_WRITE_HI = 3'd2;
   localparam logic [2:0] OP_WRITE_LO = 3'd3;
   localparam logic [2:0] OP_SMUL     = 3'd4;
   localparam logic [2:0] OP_UMUL     = 3'd5;
   localparam logic [2:0] OP_SDIV     = 3'd6;
   localparam logic [2:0] OP_UDIV     = 3'd7;

   localparam int MUL_CYCLES = WIDTH / MUL_STEP;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam int PP_W       = WIDTH + MUL_STEP;

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIXUP
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [2*WIDTH-1:0]     acc_reg, acc_next;
   logic [WIDTH-1:0]       op_a_reg, op_a_next;
   logic [WIDTH-1:0]       op_b_reg, op_b_next;
   logic                   sign_a_reg, sign_a_next;
   logic                   sign_b_reg, sign_b_next;
   logic                   is_div_reg, is_div_next;
   logic [WIDTH-1:0]       hi_reg, hi_next;
   logic [WIDTH-1:0]       lo_reg, lo_next;
   logic                   done_reg, done_next;

   // Operand magnitudes captured at start; unsigned ops force the sign bits to 0.
   logic                   op_signed;
   logic                   in_sign_a, in_sign_b;
   logic [WIDTH-1:0]       in_mag_a, in_mag_b;

   assign op_signed = (operation == OP_SMUL) || (operation == OP_SDIV);
   assign in_sign_a = op_signed & operand1[WIDTH-1];
   assign in_sign_b = op_signed & operand2[WIDTH-1];
   assign in_mag_a  = in_sign_a ? -operand1 : operand1;
   assign in_mag_b  = in_sign_b ? -operand2 : operand2;

   // Multiply step: acc holds {partial_high, remaining multiplier bits}.
   logic [PP_W-1:0]        pp_term [MUL_STEP];
   logic [PP_W-1:0]        pp_sum;
   logic [PP_W-1:0]        mul_upper;
   logic [2*WIDTH-1:0]     mul_acc_step;

   genvar gi;
   generate
      for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
         assign pp_term[gi] = acc_reg[gi] ? (PP_W'(op_a_reg) << gi) : '0;
      end
   endgenerate

   always_comb begin
      pp_sum = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         pp_sum = pp_sum + pp_term[i];
      end
   end

   assign mul_upper    = {{MUL_STEP{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]} + pp_sum;
   assign mul_acc_step = {mul_upper, acc_reg[WIDTH-1:MUL_STEP]};

   // Restoring divide step: acc holds {partial_remainder, dividend/quotient}.
   logic [WIDTH:0]         div_shift;
   logic [WIDTH-1:0]       div_diff;
   logic                   div_ge;
   logic [2*WIDTH-1:0]     div_acc_step;

   assign div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign div_ge       = div_shift >= {1'b0, op_b_reg};
   assign div_diff     = div_shift[WIDTH-1:0] - op_b_reg;
   assign div_acc_step = div_ge ? {div_diff, acc_reg[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

   // Sign application for the FIXUP cycle.
   logic [2*WIDTH-1:0]     prod_fix;
   logic [WIDTH-1:0]       quo_fix;
   logic [WIDTH-1:0]       rem_fix;
   logic [WIDTH-1:0]       dividend_raw;
   logic                   signs_differ;

   assign signs_differ = sign_a_reg ^ sign_b_reg;
   assign prod_fix     = signs_differ ? -acc_reg : acc_reg;
   assign quo_fix      = signs_differ ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
   assign rem_fix      = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
   assign dividend_raw = sign_a_reg ? -op_a_reg : op_a_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         sign_a_reg <= 1'b0;
         sign_b_reg <= 1'b0;
         is_div_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         acc_reg    <= acc_next;
         op_a_reg   <= op_a_next;
         op_b_reg   <= op_b_next;
         sign_a_reg <= sign_a_next;
         sign_b_reg <= sign_b_next;
         is_div_reg <= is_div_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      acc_next    = acc_reg;
      op_a_next   = op_a_reg;
      op_b_next   = op_b_reg;
      sign_a_next = sign_a_reg;
      sign_b_next = sign_b_reg;
      is_div_next = is_div_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      done_next   = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start && !cancel) begin
               case (operation)
                  OP_WRITE_HI: hi_next = operand1;
                  OP_WRITE_LO: lo_next = operand1;
                  OP_SMUL, OP_UMUL: begin
                     state_next  = S_MUL;
                     cnt_next    = MUL_LAST;
                     acc_next    = {{WIDTH{1'b0}}, in_mag_b};
                     op_a_next   = in_mag_a;
                     op_b_next   = in_mag_b;
                     sign_a_next = in_sign_a;
                     sign_b_next = in_sign_b;
                     is_div_next = 1'b0;
                  end
                  OP_SDIV, OP_UDIV: begin
                     state_next  = S_DIV;
                     cnt_next    = DIV_LAST;
                     acc_next    = {{WIDTH{1'b0}}, in_mag_a};
                     op_a_next   = in_mag_a;
                     op_b_next   = in_mag_b;
                     sign_a_next = in_sign_a;
                     sign_b_next = in_sign_b;
                     is_div_next = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_next = mul_acc_step;
            if (cnt_reg == '0) state_next = S_FIXUP;
            else               cnt_next   = cnt_reg - CNT_ONE;
         end
         S_DIV: begin
            acc_next = div_acc_step;
            if (cnt_reg == '0) state_next = S_FIXUP;
            else               cnt_next   = cnt_reg - CNT_ONE;
         end
         S_FIXUP: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            if (!is_div_reg) begin
               {hi_next, lo_next} = prod_fix;
            end else if (op_b_reg == '0) begin
               // Divide by zero ran full length; only the non-keep mode writes.
               if (!DIV_ZERO_KEEP) begin
                  hi_next = dividend_raw;
                  lo_next = '1;
               end
            end else begin
               hi_next = rem_fix;
               lo_next = quo_fix;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Flush wins over everything in flight, including the FIXUP write.
      if (cancel && (state_reg != S_IDLE)) begin
         state_next = S_IDLE;
         cnt_next   = '0;
         done_next  = 1'b0;
         hi_next    = hi_reg;
         lo_next    = lo_reg;
      end
   end

   assign busy = (state_reg != S_IDLE);
   assign done = done_reg;

   always_comb begin
      dataRead = '0;
      if (operation == OP_READ_HI)      dataRead = hi_reg;
      else if (operation == OP_READ_LO) dataRead = lo_reg;
   end

endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// Bench for iterative_mul_div_unit: two instances (step 1 / keep, step 4 / no-keep)
// checked every cycle against a transaction-level arithmetic model, plus literal cases.
module tb_iterative_mul_div_unit;

   localparam int W = 32;

   logic          clock;
   logic          reset;
   logic          start;
   logic          cancel;
   logic [W-1:0]  operand1;
   logic [W-1:0]  operand2;
   logic [2:0]    operation;
   logic          busy0, done0, busy1, done1;
   logic [W-1:0]  dr0, dr1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   int txn_id = 0;

   // Model state per instance: architectural HI/LO, remaining busy cycles, pending result.
   logic [W-1:0]  m_hi [2];
   logic [W-1:0]  m_lo [2];
   logic [W-1:0]  p_hi [2];
   logic [W-1:0]  p_lo [2];
   bit            p_skip [2];
   bit            m_done [2];
   int            m_rem [2];

   iterative_mul_div_unit #(.WIDTH(W), .MUL_STEP(1), .DIV_ZERO_KEEP(1'b1)) dut0 (
      .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
      .operation(operation), .start(start), .cancel(cancel),
      .busy(busy0), .done(done0), .dataRead(dr0)
   );

   iterative_mul_div_unit #(.WIDTH(W), .MUL_STEP(4), .DIV_ZERO_KEEP(1'b0)) dut1 (
      .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
      .operation(operation), .start(start), .cancel(cancel),
      .busy(busy1), .done(done1), .dataRead(dr1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void model_result(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit keep,
                                        output logic [31:0] hi, output logic [31:0] lo,
                                        output bit skip);
      longint     sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      skip = 1'b0;
      if ((op == 3'd6 || op == 3'd7) && b == 32'd0) begin
         if (keep) skip = 1'b1;
         else begin
            hi = a;
            lo = 32'hFFFF_FFFF;
         end
      end else begin
         case (op)
            3'd4: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            3'd5: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            3'd6: begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
            3'd7: begin hi = a % b; lo = a / b; end
            default: ;
         endcase
      end
   endfunction

   function automatic int latency(input int k, input logic [2:0] op);
      if (op >= 3'd6) return W + 1;
      return (k == 0) ? (W / 1 + 1) : (W / 4 + 1);
   endfunction

   // Reference model, advanced on every active edge from the inputs held before it.
   initial begin
      for (int k = 0; k < 2; k++) begin
         m_hi[k] = '0; m_lo[k] = '0; p_hi[k] = '0; p_lo[k] = '0;
         p_skip[k] = 0; m_done[k] = 0; m_rem[k] = 0;
      end
      forever begin
         @(posedge clock);
         for (int k = 0; k < 2; k++) begin
            if (reset) begin
               m_hi[k] = '0; m_lo[k] = '0; m_rem[k] = 0; m_done[k] = 0;
            end else begin
               m_done[k] = 0;
               if (m_rem[k] > 0) begin
                  if (cancel) m_rem[k] = 0;
                  else if (m_rem[k] == 1) begin
                     if (!p_skip[k]) begin
                        m_hi[k] = p_hi[k];
                        m_lo[k] = p_lo[k];
                     end
                     m_done[k] = 1;
                     m_rem[k] = 0;
                  end else m_rem[k] = m_rem[k] - 1;
               end else if (start && !cancel) begin
                  if (operation == 3'd2) m_hi[k] = operand1;
                  else if (operation == 3'd3) m_lo[k] = operand1;
                  else if (operation >= 3'd4) begin
                     model_result(operation, operand1, operand2, (k == 0),
                                  p_hi[k], p_lo[k], p_skip[k]);
                     m_rem[k] = latency(k, operation);
                     if (k == 0) begin
                        txn_id++;
                        $display("txn %0d: op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h keep=%0d",
                                 txn_id, operation, operand1, operand2, p_hi[k], p_lo[k], p_skip[k]);
                     end
                  end
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_read(input int k);
      if (operation == 3'd0) return m_hi[k];
      if (operation == 3'd1) return m_lo[k];
      return '0;
   endfunction

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy0", 32'(busy0), 32'(m_rem[0] != 0));
         chk("done0", 32'(done0), 32'(m_done[0]));
         chk("read0", dr0, exp_read(0));
         chk("busy1", 32'(busy1), 32'(m_rem[1] != 0));
         chk("done1", 32'(done1), 32'(m_done[1]));
         chk("read1", dr1, exp_read(1));
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int c0, output int c1, output int d0, output int d1);
      operation = op; operand1 = a; operand2 = b; start = 1'b1;
      step();
      start = 1'b0;
      operation = 3'd0;
      c0 = 0; c1 = 0; d0 = 0; d1 = 0;
      for (int i = 0; i < 60; i++) begin
         if (busy0) c0++;
         if (busy1) c1++;
         if (done0) d0++;
         if (done1) d1++;
         step();
      end
   endtask

   task automatic write_reg(input logic [2:0] op, input logic [31:0] v);
      operation = op; operand1 = v; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic read_lit(input string name, input logic [2:0] op,
                           input logic [31:0] e0, input logic [31:0] e1);
      operation = op;
      #1;
      chk({name, "_dut0"}, dr0, e0);
      chk({name, "_dut1"}, dr1, e1);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   int c0, c1, d0, d1;

   initial begin
      reset = 1'b1; start = 1'b0; cancel = 1'b0; operation = 3'd0;
      operand1 = '0; operand2 = '0;
      step();
      chk_en = 1;
      step();
      reset = 1'b0;
      chk("reset_busy0", 32'(busy0), 32'd0);
      chk("reset_done0", 32'(done0), 32'd0);
      read_lit("reset_hi", 3'd0, 32'd0, 32'd0);
      read_lit("reset_lo", 3'd1, 32'd0, 32'd0);

      run_op(3'd4, 32'hFFFF_FFFD, 32'h0000_0007, c0, c1, d0, d1);
      chk("smul_busy_cycles0", c0, 33);
      chk("smul_busy_cycles1", c1, 9);
      chk("smul_done_count0", d0, 1);
      chk("smul_done_count1", d1, 1);
      read_lit("smul_hi", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_lit("smul_lo", 3'd1, 32'hFFFF_FFEB, 32'hFFFF_FFEB);

      run_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0, c1, d0, d1);
      chk("umul_busy_cycles1", c1, 9);
      read_lit("umul_hi", 3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
      read_lit("umul_lo", 3'd1, 32'h0000_0001, 32'h0000_0001);

      run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, c0, c1, d0, d1);
      chk("sdiv_busy_cycles0", c0, 33);
      chk("sdiv_busy_cycles1", c1, 33);
      read_lit("sdiv_hi", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_lit("sdiv_lo", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);

      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, c0, c1, d0, d1);
      read_lit("sdiv_ovf_hi", 3'd0, 32'h0, 32'h0);
      read_lit("sdiv_ovf_lo", 3'd1, 32'h8000_0000, 32'h8000_0000);

      write_reg(3'd2, 32'h1234);
      write_reg(3'd3, 32'h5678);
      run_op(3'd7, 32'd9, 32'd0, c0, c1, d0, d1);
      chk("divzero_done0", d0, 1);
      chk("divzero_done1", d1, 1);
      chk("divzero_busy_cycles0", c0, 33);
      read_lit("divzero_hi", 3'd0, 32'h1234, 32'h9);
      read_lit("divzero_lo", 3'd1, 32'h5678, 32'hFFFF_FFFF);

      // Cancel on the 10th busy cycle of a step-1 multiply (step-4 copy has finished).
      operation = 3'd4; operand1 = 32'd5; operand2 = 32'd6; start = 1'b1;
      step();
      start = 1'b0; operation = 3'd0;
      repeat (9) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("cancel_busy0", 32'(busy0), 32'd0);
      chk("cancel_done0", 32'(done0), 32'd0);
      read_lit("cancel_hi", 3'd0, 32'h1234, 32'h0);
      read_lit("cancel_lo", 3'd1, 32'h5678, 32'd30);
      run_op(3'd5, 32'd3, 32'd4, c0, c1, d0, d1);
      chk("after_cancel_done0", d0, 1);
      read_lit("after_cancel_hi", 3'd0, 32'h0, 32'h0);
      read_lit("after_cancel_lo", 3'd1, 32'd12, 32'd12);

      // Starts while busy are ignored; reset mid-divide clears everything.
      operation = 3'd7; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
      step();
      operation = 3'd2; operand1 = 32'hAAAA;
      step();
      operation = 3'd4; operand1 = 32'd3; operand2 = 32'd3;
      step();
      start = 1'b0;
      read_lit("busy_read_lo", 3'd1, 32'd12, 32'd12);
      read_lit("busy_read_hi", 3'd0, 32'h0, 32'h0);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset_busy0", 32'(busy0), 32'd0);
      chk("midreset_busy1", 32'(busy1), 32'd0);
      chk("midreset_done0", 32'(done0), 32'd0);
      read_lit("midreset_hi", 3'd0, 32'h0, 32'h0);
      read_lit("midreset_lo", 3'd1, 32'h0, 32'h0);

      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 699) == 0);
         cancel    = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 2) == 0);
         operation = 3'($urandom_range(0, 7));
         operand1  = rnd_operand();
         operand2  = rnd_operand();
         step();
      end
      reset = 1'b0; cancel = 1'b0; start = 1'b0; operation = 3'd0;
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
